// File: rtl/acumulador_seq.sv
// Sequencing controller for the 16-bit accumulator: clears it, loads a batch of
// N_OPS operands from a valid/ready stream, pulses transf and captures the sum.
module acumulador_seq #(
  parameter int WIDTH = 16,
  parameter int N_OPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic [WIDTH-1:0] acc_in,
  output logic             acc_load,
  output logic             acc_transf,
  output logic             acc_clear,
  input  logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(N_OPS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_OPS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLR   = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] XFER  = 3'd4;
  localparam logic [2:0] CAPT  = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          hs;

  assign hs = (state == FEED) && op_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLR;
      CLR:     state_nxt = FEED;
      FEED:    if (hs && (cnt == LAST)) state_nxt = DRAIN;
      DRAIN:   state_nxt = XFER;
      XFER:    state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_in   <= '0;
      acc_load <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      // load trails the handshake by one cycle, so the last one lands in DRAIN
      acc_load <= hs;
      done     <= (state == CAPT);
      if (hs) acc_in <= op_data;
      if (state == CAPT) result <= acc_out;
      if (state == CLR) cnt <= '0;
      else if (hs) cnt <= cnt + CW'(1);
    end
  end

  // Remaining strobes are pure state decodes, so nothing combinational reaches an output from an input.
  assign op_ready   = (state == FEED);
  assign acc_clear  = (state == CLR);
  assign acc_transf = (state == XFER);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_acumulador_seq.sv
// Directed bench for acumulador_seq with a behavioural accumulator attached.
module tb_acumulador_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op_valid;
  logic [15:0] op_data;
  logic        op_ready;
  logic [15:0] acc_in;
  logic        acc_load;
  logic        acc_transf;
  logic        acc_clear;
  logic [15:0] acc_out;
  logic [15:0] result;
  logic        done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int conflicts = 0;

  acumulador_seq #(.WIDTH(16), .N_OPS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_valid(op_valid), .op_data(op_data),
    .op_ready(op_ready), .acc_in(acc_in), .acc_load(acc_load), .acc_transf(acc_transf),
    .acc_clear(acc_clear), .acc_out(acc_out), .result(result), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator model: clear / add / transfer at the rising edge.
  logic [15:0] sum;
  initial begin
    sum = 16'h0;
    acc_out = 16'h0;
  end
  always @(posedge clk) begin
    if (acc_clear) sum <= 16'h0;
    else if (acc_load) sum <= sum + acc_in;
    if (acc_transf) acc_out <= sum;
  end

  always @(negedge clk)
    if ((32'(acc_clear) + 32'(acc_load) + 32'(acc_transf)) > 1) conflicts++;

  // Runs one batch from an IDLE negedge; returns at the negedge where done is seen.
  // Trace bit k holds the strobe sampled after the k-th edge following the start edge.
  task automatic drive_batch(input logic [15:0] o0, o1, o2, o3, input bit gap, input bit hold,
                             input bit mid, output int edges, output logic [31:0] ld_tr,
                             output logic [31:0] cl_tr, output logic [31:0] tf_tr,
                             output logic [15:0] res, output bit to);
    logic [15:0] v [4];
    int idx;
    int fcyc;
    bit hs_now;
    v = '{o0, o1, o2, o3};
    edges = 0; idx = 0; fcyc = 0; to = 0;
    ld_tr = '0; cl_tr = '0; tf_tr = '0;
    start = 1'b1;
    op_valid = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (edges < 32) begin
        ld_tr[edges] = acc_load;
        cl_tr[edges] = acc_clear;
        tf_tr[edges] = acc_transf;
      end
      if (done) break;
      if (edges >= 40) begin
        to = 1;
        break;
      end
      start = (mid && op_ready && fcyc == 1) ? 1'b1 : hold;
      if (op_ready && idx < 4) begin
        op_valid = gap ? (fcyc % 2 == 0) : 1'b1;
        op_data = v[idx];
        fcyc++;
      end else begin
        op_valid = 1'b0;
      end
      hs_now = op_valid && op_ready;
      @(posedge clk);
      edges++;
      if (hs_now) idx++;
    end
    op_valid = 1'b0;
    res = result;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op_valid = 1'b1; op_data = 16'hABCD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({op_ready, acc_in, acc_load, acc_transf, acc_clear, result, done, busy} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b in=%h ld=%b tf=%b clr=%b res=%h done=%b busy=%b, want all 0",
               op_ready, acc_in, acc_load, acc_transf, acc_clear, result, done, busy);
    end
    rst = 1'b0; start = 1'b0; op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, op_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle: busy/done/ready=%b, want 000", {busy, done, op_ready});
    end
  endtask

  task automatic test_basic;
    int e; logic [31:0] ld, cl, tf; logic [15:0] r; bit to;
    drive_batch(16'h1, 16'h2, 16'h4, 16'h8, 0, 0, 0, e, ld, cl, tf, r, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got %b want 0", to); end
    n_cmp++; if (e !== 8) begin n_err++; $display("FAIL basic_latency: got %0d want 8", e); end
    n_cmp++; if (r !== 16'h000F) begin n_err++; $display("FAIL basic_result: got %h want 000f", r); end
    n_cmp++; if (cl !== 32'h1) begin n_err++; $display("FAIL basic_clear: got %h want 1", cl); end
    n_cmp++; if (ld !== 32'h3C) begin n_err++; $display("FAIL basic_loads: got %h want 3c", ld); end
    n_cmp++; if (tf !== 32'h40) begin n_err++; $display("FAIL basic_transf: got %h want 40", tf); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({done, busy, result} !== {2'b00, 16'h000F}) begin
      n_err++;
      $display("FAIL basic_hold: done=%b busy=%b res=%h, want 0 0 000f", done, busy, result);
    end
  endtask

  task automatic test_gapped;
    int e; logic [31:0] ld, cl, tf; logic [15:0] r; bit to;
    drive_batch(16'h1, 16'h2, 16'h4, 16'h8, 1, 0, 0, e, ld, cl, tf, r, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL gap_timeout: got %b want 0", to); end
    n_cmp++; if (e !== 11) begin n_err++; $display("FAIL gap_latency: got %0d want 11", e); end
    n_cmp++; if (r !== 16'h000F) begin n_err++; $display("FAIL gap_result: got %h want 000f", r); end
    n_cmp++; if (ld !== 32'h154) begin n_err++; $display("FAIL gap_loads: got %h want 154", ld); end
    n_cmp++; if (tf !== 32'h200) begin n_err++; $display("FAIL gap_transf: got %h want 200", tf); end
  endtask

  task automatic test_wrap;
    int e; logic [31:0] ld, cl, tf; logic [15:0] r; bit to;
    drive_batch(16'hFFFF, 16'h2, 16'h0, 16'h0, 0, 0, 0, e, ld, cl, tf, r, to);
    n_cmp++; if (r !== 16'h0001) begin n_err++; $display("FAIL wrap_result: got %h want 0001", r); end
  endtask

  task automatic test_back_to_back;
    int e; logic [31:0] ld, cl, tf; logic [15:0] r; bit to;
    drive_batch(16'h5, 16'h5, 16'h5, 16'h5, 0, 1, 0, e, ld, cl, tf, r, to);
    n_cmp++; if (r !== 16'h0014) begin n_err++; $display("FAIL b2b_a_result: got %h want 0014", r); end
    n_cmp++; if (e !== 8) begin n_err++; $display("FAIL b2b_a_latency: got %0d want 8", e); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap: busy=%b want 0", busy); end
    drive_batch(16'h1, 16'h1, 16'h1, 16'h1, 0, 0, 0, e, ld, cl, tf, r, to);
    n_cmp++; if (cl !== 32'h1) begin n_err++; $display("FAIL b2b_b_clear: got %h want 1", cl); end
    n_cmp++; if (r !== 16'h0004) begin n_err++; $display("FAIL b2b_b_result: got %h want 0004", r); end
    n_cmp++; if (e !== 8) begin n_err++; $display("FAIL b2b_b_latency: got %0d want 8", e); end
  endtask

  task automatic test_ignored_start;
    int e; logic [31:0] ld, cl, tf; logic [15:0] r; bit to;
    drive_batch(16'h10, 16'h20, 16'h30, 16'h40, 0, 0, 1, e, ld, cl, tf, r, to);
    n_cmp++; if (e !== 8) begin n_err++; $display("FAIL mid_start_latency: got %0d want 8", e); end
    n_cmp++; if (cl !== 32'h1) begin n_err++; $display("FAIL mid_start_clear: got %h want 1", cl); end
    n_cmp++; if (r !== 16'h00A0) begin n_err++; $display("FAIL mid_start_result: got %h want 00a0", r); end
  endtask

  task automatic test_reset_mid;
    int e; logic [31:0] ld, cl, tf; logic [15:0] r; bit to;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      op_valid = 1'b1; op_data = 16'h3;
      @(posedge clk);
    end
    @(negedge clk);
    n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_feed: ready=%b want 1", op_ready); end
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({op_ready, acc_in, acc_load, acc_transf, acc_clear, result, done, busy} !== 36'h0) begin
      n_err++;
      $display("FAIL rmid_outputs: ready=%b in=%h ld=%b tf=%b clr=%b res=%h done=%b busy=%b, want all 0",
               op_ready, acc_in, acc_load, acc_transf, acc_clear, result, done, busy);
    end
    rst = 1'b0; start = 1'b0; op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_batch(16'h3, 16'h3, 16'h3, 16'h3, 0, 0, 0, e, ld, cl, tf, r, to);
    n_cmp++; if (r !== 16'h000C) begin n_err++; $display("FAIL rmid_result: got %h want 000c", r); end
    n_cmp++; if (e !== 8) begin n_err++; $display("FAIL rmid_latency: got %0d want 8", e); end
  endtask

  task automatic test_strobe_exclusive;
    n_cmp++;
    if (conflicts !== 0) begin
      n_err++;
      $display("FAIL strobe_exclusive: %0d cycles with several strobes, want 0", conflicts);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_valid = 1'b0; op_data = 16'h0;
    test_reset();
    test_basic();
    test_gapped();
    test_wrap();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_strobe_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
